// File: rtl/ifq_pkg.sv
// Shared types for the instruction prefetch queue: FSM states, PC width and
// the queue entry layout (instruction plus the address of the next word).
package ifq_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc_plus_1;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of DEPTH prefetched entries. Flush wins over push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  ifq_entry_t               wdata,
  output ifq_entry_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t       store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = store[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are meaningless until counted, so no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_prefetch_q.sv
// Instruction prefetch queue between a multi-cycle instruction memory and the
// IF/ID register. Issues sequential word fetches, buffers {instr, pc+1},
// flushes on redirect and stops issuing on halt.
// Optional macro IFQ_BYPASS_EN: forward a returning word straight to the
// outputs when the queue is empty (zero-latency path).
module ifetch_prefetch_q
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] pc_plus_1,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        hlt
);

  ifq_state_t              state;
  logic [PC_W-1:0]         fetch_pc;
  ifq_entry_t              head;
  ifq_entry_t              ack_entry;
  ifq_entry_t              shown_p1;
  logic [$clog2(DEPTH):0]  count;
  logic                    empty;
  logic                    full;
  logic                    ack_wait;
  logic                    push;
  logic                    pop;
  logic                    space_after;

  // A word returning for the live request (not cancelled by redirect)
  assign ack_wait            = (state == WAIT) & mem_ack & ~redirect;
  assign ack_entry.instr     = mem_rdata;
  assign ack_entry.pc_plus_1 = mem_addr + 16'd1;
  assign pop                 = ~empty & instr_ready;
  // Room for one more outstanding word once the current one is pushed
  assign space_after         = (int'(count) + 1) < DEPTH;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass = ack_wait & empty;
  assign push   = ack_wait & ~(bypass & instr_ready);
`else
  assign push   = ack_wait;
`endif

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (ack_entry),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Remember the last presented entry so outputs hold while the queue is empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shown_p1 <= '0;
    end else if (!empty) begin
      shown_p1 <= head;
`ifdef IFQ_BYPASS_EN
    end else if (bypass) begin
      shown_p1 <= ack_entry;
`endif
    end
  end

  // Head presentation to the IF/ID register
  always_comb begin
    instr_valid = ~empty;
    instr       = empty ? shown_p1.instr     : head.instr;
    pc_plus_1   = empty ? shown_p1.pc_plus_1 : head.pc_plus_1;
`ifdef IFQ_BYPASS_EN
    if (bypass) begin
      instr_valid = 1'b1;
      instr       = ack_entry.instr;
      pc_plus_1   = ack_entry.pc_plus_1;
    end
`endif
  end

  // Fetch FSM: request issue, back-to-back streaming, redirect and drop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (!hlt && !full) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end else begin
              // request cannot be withdrawn; swallow its data later
              state <= DROP;
            end
          end else if (mem_ack) begin
            fetch_pc <= fetch_pc + 16'd1;
            if (!hlt && space_after) begin
              mem_addr <= fetch_pc + 16'd1;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_q.sv
// Scoreboard bench for ifetch_prefetch_q. Stimulus queues expected memory
// addresses and expected delivered entries; the memory model and the output
// monitor pop and compare independently. IFQ_BYPASS_EN selects bypass checks.
module tb_ifetch_prefetch_q;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] pc_plus_1;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;

  int checks = 0;
  int fails  = 0;

  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  bit          mem_auto;
  int          mem_lat;
  int          wait_cnt = 0;
  int          req_cnt  = 0;
  logic        man_ack;
  logic [15:0] man_rdata;
  logic [31:0] mon_e;
  logic [15:0] exp_a;

  always #5 clk = ~clk;

  ifetch_prefetch_q dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_plus_1   (pc_plus_1),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hlt         (hlt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_req(input logic [15:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic exp_out(input logic [15:0] a);
    exp_data_q.push_back({a ^ 16'hA5A5, a + 16'd1});
  endtask

  // Memory model: acks after mem_lat wait cycles, or replays manual drive
  always @(posedge clk) begin
    #2;
    if (!mem_auto) begin
      mem_ack   = man_ack;
      mem_rdata = man_rdata;
    end else begin
      mem_ack = 1'b0;
      if (!rst_n || !mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt >= mem_lat) begin
        wait_cnt  = 0;
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ 16'hA5A5;
        req_cnt++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL mem_req_unexpected: got addr %h, expected no request", mem_addr);
        end else begin
          exp_a = exp_addr_q.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(exp_a));
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Output monitor: every accepted head must match the next expected entry
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL out_unexpected: got instr %h pc_plus_1 %h, expected none", instr, pc_plus_1);
      end else begin
        mon_e = exp_data_q.pop_front();
        check("instr", 32'(instr), 32'(mon_e[31:16]));
        check("pc_plus_1", 32'(pc_plus_1), 32'(mon_e[15:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bit found;
    rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    hlt = 1'b0; mem_auto = 1'b1; mem_lat = 0; man_ack = 1'b0; man_rdata = 16'h0000;
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0000);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'h0000);
    check("rst_pc_plus_1", 32'(pc_plus_1), 32'h0000);

    // Streaming with single-cycle ack: addresses 0..7
    for (int a = 0; a < 8; a++) begin
      exp_req(16'(a));
      exp_out(16'(a));
    end
    rst_n = 1'b1;
    repeat (8) tick();
    hlt = 1'b1;
    repeat (6) tick();
    check("stream_req_cnt", 32'(req_cnt), 32'd8);
    check("stream_idle_req", 32'(mem_req), 32'd0);
    check("stream_drained", 32'(instr_valid), 32'd0);

    // Fill the queue with the consumer stalled
    base = req_cnt;
    for (int a = 8; a < 12; a++) begin
      exp_req(16'(a));
      exp_out(16'(a));
    end
    instr_ready = 1'b0; hlt = 1'b0;
    repeat (10) tick();
    check("full_req_cnt", 32'(req_cnt - base), 32'd4);
    check("full_mem_req", 32'(mem_req), 32'd0);
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_head_instr", 32'(instr), 32'(16'h0008 ^ 16'hA5A5));
    check("full_head_pc", 32'(pc_plus_1), 32'h0009);
    instr_ready = 1'b1; hlt = 1'b1;
    repeat (6) tick();
    check("full_drained", 32'(instr_valid), 32'd0);

    // Redirect while waiting on a slow request at address 5
    mem_lat = 3;
    redirect = 1'b1; redirect_pc = 16'h0005;
    exp_req(16'h0005);
    tick();
    redirect = 1'b0; hlt = 1'b0;
    tick();
    check("redir_req", 32'(mem_req), 32'd1);
    check("redir_addr5", 32'(mem_addr), 32'h0005);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    exp_req(16'h0040);
    exp_out(16'h0040);
    tick();
    redirect = 1'b0;
    check("redir_valid_low", 32'(instr_valid), 32'd0);
    check("drop_req_held", 32'(mem_req), 32'd1);
    check("drop_addr_held", 32'(mem_addr), 32'h0005);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req && mem_addr == 16'h0040) found = 1'b1;
      else tick();
    end
    check("redir_target_issued", 32'(found), 32'd1);
    hlt = 1'b1;
    repeat (8) tick();
    check("redir_drained", 32'(instr_valid), 32'd0);
    check("redir_idle", 32'(mem_req), 32'd0);

    // Redirect, ack and pop all in the same cycle
    mem_auto = 1'b0; man_ack = 1'b0; mem_lat = 0; hlt = 1'b0; instr_ready = 1'b0;
    tick();
    check("same_req41", 32'(mem_addr), 32'h0041);
    man_ack = 1'b1; man_rdata = 16'h0041 ^ 16'hA5A5;
    tick();
    check("same_req42", 32'(mem_addr), 32'h0042);
    check("same_valid", 32'(instr_valid), 32'd1);
    check("same_head", 32'(instr), 32'(16'h0041 ^ 16'hA5A5));
    man_ack = 1'b1; man_rdata = 16'h0042 ^ 16'hA5A5;
    redirect = 1'b1; redirect_pc = 16'h0080; instr_ready = 1'b1;
    tick();
    man_ack = 1'b0; redirect = 1'b0;
    check("same_flushed", 32'(instr_valid), 32'd0);
    check("same_req_low", 32'(mem_req), 32'd0);
    tick();
    check("same_resume_req", 32'(mem_req), 32'd1);
    check("same_resume_addr", 32'(mem_addr), 32'h0080);
    exp_req(16'h0080);
    exp_out(16'h0080);
    hlt = 1'b1; mem_auto = 1'b1;
    repeat (6) tick();
    check("same_drained", 32'(instr_valid), 32'd0);

    // Halt during an outstanding request at address 7
    redirect = 1'b1; redirect_pc = 16'h0007;
    tick();
    redirect = 1'b0; hlt = 1'b0; mem_lat = 3;
    exp_req(16'h0007);
    exp_out(16'h0007);
    tick();
    check("hlt_req7", 32'(mem_addr), 32'h0007);
    hlt = 1'b1;
    repeat (8) tick();
    check("hlt_no_req", 32'(mem_req), 32'd0);
    check("hlt_drained", 32'(instr_valid), 32'd0);

    // Reset in the middle of a request, then a stale ack
    mem_auto = 1'b0; man_ack = 1'b0; hlt = 1'b0;
    tick();
    check("mid_req8", 32'(mem_addr), 32'h0008);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'h0000);
    check("mid_rst_instr", 32'(instr), 32'h0000);
    man_ack = 1'b1; man_rdata = 16'hDEAD;
    tick();
    man_ack = 1'b0;
    check("stale_ignored", 32'(instr_valid), 32'd0);
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", 32'(mem_addr), 32'h0000);
    tick();
    man_ack = 1'b1; man_rdata = 16'hA5A5; hlt = 1'b1;
    exp_out(16'h0000);
    #2;
`ifdef IFQ_BYPASS_EN
    check("byp_valid_same", 32'(instr_valid), 32'd1);
    check("byp_instr", 32'(instr), 32'h0000A5A5);
    check("byp_pc", 32'(pc_plus_1), 32'h0001);
`else
    check("nobyp_valid_same", 32'(instr_valid), 32'd0);
`endif
    tick();
    man_ack = 1'b0;
    #2;
`ifdef IFQ_BYPASS_EN
    check("byp_not_pushed", 32'(instr_valid), 32'd0);
`else
    check("nobyp_valid_next", 32'(instr_valid), 32'd1);
    check("nobyp_pc", 32'(pc_plus_1), 32'h0001);
`endif
    repeat (4) tick();
    check("final_out_queue", 32'(exp_data_q.size()), 32'd0);
    check("final_addr_queue", 32'(exp_addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch_q.md
Name: ifetch_prefetch_q

Overview:
- Instruction prefetch queue between a multi-cycle instruction memory and the IF/ID pipeline register.
- Issues sequential word-addressed fetches and buffers returned instructions with their PC+1.
- Delivers them to the IF/ID register under valid/ready.
- Flushes on jump/branch redirect and freezes fetch on halt.

Parameters:
- DEPTH, 4, queue entries (power of two, 2..16).
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mem_req  out  1  fetch request; held high until mem_ack
- mem_addr  out  16  word address of the request; stable while mem_req is high
- mem_ack  in  1  one-cycle pulse; mem_rdata valid this cycle
- mem_rdata  in  16  returned instruction
- instr_valid  out  1  head entry valid
- instr  out  16  head instruction
- pc_plus_1  out  16  head address + 1
- instr_ready  in  1  IF/ID accepts head (low = stall)
- redirect  in  1  jump/branch taken
- redirect_pc  in  16  new fetch address
- hlt  in  1  halt decoded; stop issuing new fetches

Behaviour:
- Reset values:
  - Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
  - On rst_n=0 at a clk edge: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=16'h0000, pc_plus_1=16'h0000, count=0, fetch_pc=RESET_PC, state=IDLE.
- Pop: occurs when instr_valid & instr_ready at the clk edge; the head advances.
- Push: occurs on mem_ack in state WAIT.
  - The entry is {mem_rdata, mem_addr+1}.
  - fetch_pc increments by 1, wrapping 16'hFFFF -> 16'h0000.
- Capacity rule: a request is issued only if count + (request outstanding) < DEPTH, so a returned word always has space.
- State machine (states IDLE, WAIT, DROP):
  - IDLE:
    - If ~hlt and space is available: mem_req=1, mem_addr=fetch_pc, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT, mem_ack without redirect: push the entry.
    - If space remains and ~hlt, issue the next request in the same cycle (back-to-back) and stay in WAIT.
    - Otherwise go to IDLE.
  - WAIT, redirect without mem_ack: flush the queue, fetch_pc=redirect_pc, go to DROP.
    - mem_req stays high with the old address until the ack, because the request cannot be withdrawn.
  - WAIT, redirect and mem_ack in the same cycle: discard the returned data, flush, fetch_pc=redirect_pc, go to IDLE.
  - DROP: on mem_ack, discard the data and go to IDLE. New redirects in DROP only update fetch_pc.
  - IDLE + redirect: flush, fetch_pc=redirect_pc, then issue from redirect_pc next cycle.
- Simultaneous events:
  - Redirect beats pop and push in the same cycle.
  - instr_valid=0 in the cycle after a redirect.
- Full queue with instr_ready=0: the head is held stable; no request is issued.
- Empty queue: instr_valid=0; instr/pc_plus_1 hold their last value.
- Halt:
  - An outstanding request completes and is pushed.
  - Queue contents are held.
  - A redirect during hlt still flushes.
- Latency (no bypass): the first instruction reaches instr_valid one cycle after its mem_ack.
- Throughput: one instruction per cycle with a single-cycle-ack memory.
- Reset mid-request:
  - The queue and state clear; a later stale ack is ignored in IDLE.
  - The memory model must abort on reset.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when the queue is empty, in state WAIT, with no redirect, mem_ack forwards mem_rdata and mem_addr+1 combinationally to instr/pc_plus_1 with instr_valid=1 in the same cycle.
  - If instr_ready=1 that cycle, nothing is pushed.
  - Otherwise the word is pushed normally.
- Undefined: all data passes through the queue; there is one cycle of latency after mem_ack.

Decomposition:
- Package ifq_pkg:
  - state enum ifq_state_t {IDLE, WAIT, DROP};
  - localparam PC_W=16;
  - entry struct ifq_entry_t {instr, pc_plus_1}.
- Sub-module ifq_fifo: circular buffer of DEPTH ifq_entry_t.
  - push/pop/flush controls; count, empty and full outputs.
  - Pointers wrap modulo DEPTH.
- FSM and address logic live in the top module.

Test Plan:
- Reset, then single-cycle-ack memory returning mem_rdata=addr^16'hA5A5, instr_ready=1 -> mem_addr 0,1,2,3... back-to-back; instr 16'hA5A5, 16'hA5A4...; pc_plus_1 1,2,3...
- instr_ready=0 for 10 cycles, then 1 -> exactly DEPTH=4 requests issued (addr 0..3); mem_req low while full; on release, entries pop in order with no loss or duplication.
- Redirect to 16'h0040 while WAIT at addr 5 with ack delayed 3 cycles -> stale word for addr 5 discarded; next mem_addr=16'h0040; first instr_valid has pc_plus_1=16'h0041.
- Redirect and mem_ack in the same cycle, with pop also asserted -> queue empty the next cycle; no push; fetch resumes at redirect_pc.
- hlt=1 during an outstanding request at addr 7 -> that word is pushed; no further mem_req; instr_ready=1 drains the queue, then instr_valid=0 held.
- rst_n=0 mid-WAIT for one cycle, then stale ack -> ack ignored; fetch restarts at RESET_PC. With IFQ_BYPASS_EN, empty queue + ack -> instr_valid in the same cycle as mem_ack.
